// File: rtl/serial_adder_n.sv
// Bit-serial adder/subtractor: one full-adder cell, a registered carry, LSB first.
// Each operation takes WIDTH clocks in RUN and finishes with a one-cycle done strobe.
module serial_adder_n #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic [0:0]       dbg_state
);
    // Handshake: start is a request taken on any rising edge where busy is low;
    // done is a one-cycle completion strobe and sum/cout/ovf change only with it.

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);
    localparam logic [CW-1:0] PRE_MSB  = CW'(WIDTH - 2);

    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] RUN  = 1'b1;

    logic [0:0]       state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] res;
    logic             carry;
    logic             carry_msb;

    logic             s_bit;
    logic             c_next;
    logic [WIDTH-1:0] res_next;

    always_comb begin
        s_bit    = opa[0] ^ opb[0] ^ carry;
        c_next   = (opa[0] & opb[0]) | (opa[0] & carry) | (opb[0] & carry);
        res_next = {s_bit, res[WIDTH-1:1]};
    end

    assign dbg_state = state;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            opa       <= '0;
            opb       <= '0;
            res       <= '0;
            carry     <= 1'b0;
            carry_msb <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            sum       <= '0;
            cout      <= 1'b0;
            ovf       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        // Subtraction is A + ~B + ~CIN, so invert B and the carry here.
                        opa   <= a;
                        opb   <= b ^ {WIDTH{sub}};
                        carry <= cin ^ sub;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end
                end
                RUN: begin
                    carry <= c_next;
                    opa   <= {1'b0, opa[WIDTH-1:1]};
                    opb   <= {1'b0, opb[WIDTH-1:1]};
                    res   <= res_next;
                    if (cnt == PRE_MSB) begin
                        carry_msb <= c_next;
                    end
                    if (cnt == LAST_BIT) begin
                        sum   <= res_next;
                        cout  <= c_next;
                        ovf   <= carry_msb ^ c_next;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_adder_n.sv
// Bench for serial_adder_n: directed WIDTH=8 vectors, handshake/abort sequences,
// and an exhaustive WIDTH=2 sweep against an arithmetic reference.
module tb_serial_adder_n;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic       sub;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic       sub;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;
    logic       ovf;
    logic [0:0] dbg_state;

    logic       start2;
    logic       sub2;
    logic [1:0] a2;
    logic [1:0] b2;
    logic       cin2;
    logic       busy2;
    logic       done2;
    logic [1:0] sum2;
    logic       cout2;
    logic       ovf2;
    logic [0:0] dbg_state2;

    int errors;
    int checks;

    logic [7:0] prev_sum;
    logic       prev_cout;
    logic       prev_ovf;
    logic [7:0] exp_q[$];

    vec_t vecs[8];

    serial_adder_n #(.WIDTH(8)) u_dut (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b), .cin(cin),
        .busy(busy), .done(done), .sum(sum), .cout(cout), .ovf(ovf), .dbg_state(dbg_state)
    );

    serial_adder_n #(.WIDTH(2)) u_dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .sub(sub2), .a(a2), .b(b2), .cin(cin2),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2), .dbg_state(dbg_state2)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // driver tasks
    task automatic launch(input logic [7:0] va, input logic [7:0] vb, input logic vcin, input logic vsub);
        a     = va;
        b     = vb;
        cin   = vcin;
        sub   = vsub;
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    // Follows one accepted operation to its done cycle. inj >= 0 pulses start
    // with new operands during that RUN cycle; it must be ignored.
    task automatic expect_result(input string name, input logic [7:0] es, input logic ec,
                                 input logic eo, input int inj);
        logic [7:0] q_sum;
        exp_q.push_back(es);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk({name, " run"}, {busy, done, sum, cout, ovf},
                {1'b1, 1'b0, prev_sum, prev_cout, prev_ovf});
            if (i == inj) begin
                a     = 8'hAA;
                b     = 8'h55;
                cin   = 1'b1;
                sub   = 1'b1;
                start = 1'b1;
            end else if (i == inj + 1) begin
                start = 1'b0;
            end
        end
        @(negedge clk);
        q_sum = exp_q.pop_front();
        chk({name, " done"}, {busy, done}, {1'b0, 1'b1});
        chk({name, " sum"}, sum, q_sum);
        chk({name, " cout"}, cout, ec);
        chk({name, " ovf"}, ovf, eo);
        prev_sum  = es;
        prev_cout = ec;
        prev_ovf  = eo;
    endtask

    task automatic launch2(input logic [1:0] va, input logic [1:0] vb, input logic vcin, input logic vsub);
        a2     = va;
        b2     = vb;
        cin2   = vcin;
        sub2   = vsub;
        start2 = 1'b1;
        @(posedge clk);
        #1 start2 = 1'b0;
    endtask

    initial begin
        errors    = 0;
        checks    = 0;
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        start2    = 1'b0;
        sub2      = 1'b0;
        a2        = 2'd0;
        b2        = 2'd0;
        cin2      = 1'b0;

        vecs[0] = '{8'h5A, 8'h33, 1'b0, 1'b0, 8'h8D, 1'b0, 1'b1};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[2] = '{8'h7F, 8'h00, 1'b1, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 1'b0, 1'b1, 8'hF0, 1'b0, 1'b0};
        vecs[4] = '{8'h20, 8'h10, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0};
        vecs[5] = '{8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[7] = '{8'hFF, 8'hFF, 1'b1, 1'b0, 8'hFF, 1'b1, 1'b0};

        // reset with random inputs toggling
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            a     = 8'($urandom_range(0, 255));
            b     = 8'($urandom_range(0, 255));
            cin   = 1'($urandom_range(0, 1));
            sub   = 1'($urandom_range(0, 1));
            start = 1'($urandom_range(0, 1));
            @(negedge clk);
        end
        chk("reset busy", busy, 1'b0);
        chk("reset done", done, 1'b0);
        chk("reset sum", sum, 8'h00);
        chk("reset cout", cout, 1'b0);
        chk("reset ovf", ovf, 1'b0);
        chk("reset state", dbg_state, 1'b0);
        start = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            chk("idle after reset", {busy, done, sum, cout, ovf}, 12'h000);
        end

        // directed vector table
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) begin
            launch(vecs[i].a, vecs[i].b, vecs[i].cin, vecs[i].sub);
            expect_result($sformatf("vec%0d", i), vecs[i].exp_sum, vecs[i].exp_cout,
                          vecs[i].exp_ovf, -1);
            @(negedge clk);
            chk($sformatf("vec%0d pulse", i), {busy, done}, 2'b00);
            @(posedge clk);
            #1;
        end

        // start during RUN ignored, then start in the done cycle
        launch(8'h01, 8'h01, 1'b0, 1'b0);
        expect_result("hs first", 8'h02, 1'b0, 1'b0, 2);
        launch(8'h03, 8'h04, 1'b0, 1'b0);
        expect_result("hs b2b", 8'h07, 1'b0, 1'b0, -1);
        @(negedge clk);
        chk("hs no extra done", {busy, done}, 2'b00);

        // abort mid-operation
        @(posedge clk);
        #1;
        launch(8'h5A, 8'h33, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) @(negedge clk);
        chk("abort pre busy", busy, 1'b1);
        rst_n = 1'b0;
        #1;
        chk("abort outputs", {busy, done, sum, cout, ovf}, 12'h000);
        chk("abort state", dbg_state, 1'b0);
        prev_sum  = 8'h00;
        prev_cout = 1'b0;
        prev_ovf  = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            chk("abort no done", {busy, done, sum}, 10'h000);
        end

        // WIDTH=2 exhaustive sweep against signed/unsigned arithmetic
        @(posedge clk);
        #1;
        for (int k = 0; k < 64; k++) begin
            int ua, ub, uc, us, sa, sb, exact, usum;
            logic e_cout, e_ovf;
            logic [1:0] e_sum;
            bit seen;
            ua = k & 3;
            ub = (k >> 2) & 3;
            uc = (k >> 4) & 1;
            us = (k >> 5) & 1;
            sa = (ua > 1) ? ua - 4 : ua;
            sb = (ub > 1) ? ub - 4 : ub;
            if (us == 0) begin
                usum   = ua + ub + uc;
                exact  = sa + sb + uc;
                e_cout = (usum > 3);
            end else begin
                usum   = ua - ub - uc;
                exact  = sa - sb - uc;
                e_cout = (ua >= ub + uc);
            end
            e_sum = 2'(usum & 3);
            e_ovf = (exact > 1) || (exact < -2);
            launch2(2'(ua), 2'(ub), 1'(uc), 1'(us));
            seen = 1'b0;
            for (int t = 0; t < 8 && !seen; t++) begin
                @(negedge clk);
                if (done2) seen = 1'b1;
            end
            if (!seen) begin
                errors++;
                checks++;
                $display("FAIL w2 timeout: case %0d got no done expected done", k);
            end else begin
                chk($sformatf("w2 case%0d", k), {sum2, cout2, ovf2}, {e_sum, e_cout, e_ovf});
            end
            @(posedge clk);
            #1;
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
- Parametrised bit-serial adder/subtractor built around one full-adder cell and a registered carry.
- Adds two WIDTH-bit operands plus carry-in, LSB first, one bit per clock.
- Start/busy/done handshake lets a board-level controller (keys, FSM or CPU bridge) launch operations and collect SUM/COUT/OVF.
- Replaces the single-bit combinational full adder wherever wide arithmetic is needed at low LUT cost.

Parameters:
- WIDTH, 8, operand/result width in bits; legal range 2..64.

Ports:
- CLK  in  1  system clock; all state updates on the rising edge.
- RST_N  in  1  asynchronous active-low reset.
- START  in  1  request; sampled on a rising edge only when the block is idle.
- SUB  in  1  0 = A+B+CIN; 1 = A-B-CIN, computed as A + ~B + ~CIN.
- A  in  WIDTH  operand A; captured on the accepting edge.
- B  in  WIDTH  operand B; captured on the accepting edge.
- CIN  in  1  carry-in (add) or borrow-in (sub); captured on the accepting edge.
- BUSY  out  1  high while an operation is in progress.
- DONE  out  1  one-cycle pulse; result outputs are updated in the same cycle.
- SUM  out  WIDTH  result; held until the next DONE.
- COUT  out  1  raw carry out of the MSB. In SUB mode, 1 = no borrow.
- OVF  out  1  two's-complement overflow = carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (RST_N low, asynchronous):
  - State goes to IDLE.
  - BUSY = 0, DONE = 0, SUM = 0, COUT = 0, OVF = 0.
  - Bit counter, shift registers and carry are cleared.
  - Reset takes effect immediately, including mid-operation: the operation is aborted and no DONE is produced.
- States: IDLE and RUN.
- IDLE:
  - DONE is cleared unless it is being pulsed this cycle.
  - If START = 1 on an edge, the block captures:
    - opA = A
    - opB = B XOR {WIDTH{SUB}}
    - carry = CIN XOR SUB
  - On that edge it also clears the counter, sets BUSY = 1 and moves to RUN.
  - Inputs A, B, CIN and SUB are ignored at all other times.
- RUN, one bit per edge, for bit i = counter:
  - s = opA[0] ^ opB[0] ^ carry
  - carry = majority(opA[0], opB[0], carry)
  - opA and opB shift right by one.
  - The result shift register shifts right with s inserted at the MSB.
  - On the edge that processes bit WIDTH-2, the carry entering the MSB is saved for OVF.
  - On the edge that processes bit WIDTH-1:
    - SUM = final result register, COUT = final carry, OVF = saved carry XOR final carry.
    - DONE = 1, BUSY = 0, state goes to IDLE.
- Latency:
  - START is accepted on edge k.
  - BUSY is high from after edge k until edge k+WIDTH.
  - DONE is high for exactly the one cycle after edge k+WIDTH.
  - Throughput is one operation per WIDTH+1 cycles maximum.
- Back-to-back: START held or asserted during the DONE cycle is accepted on the next edge, since the block is already in IDLE.
- START during BUSY is ignored. It is not queued, and the operands in flight are unaffected.
- SUM, COUT and OVF stay stable throughout RUN, showing the previous result; they change only together with DONE.
- The counter is $clog2(WIDTH) bits wide and does not wrap past WIDTH-1.

Test Plan:
- Reset: drive RST_N = 0 with random inputs -> BUSY = 0, DONE = 0, SUM = 0x00, COUT = 0, OVF = 0. After release with START = 0 for 20 cycles, all outputs are unchanged.
- Add, WIDTH = 8: A = 0x5A, B = 0x33, CIN = 0, SUB = 0, START for 1 cycle -> BUSY high for 8 cycles, DONE high for 1 cycle, SUM = 0x8D, COUT = 0, OVF = 1.
- Carry wrap: A = 0xFF, B = 0x01, CIN = 0 -> SUM = 0x00, COUT = 1, OVF = 0. Also A = 0x7F, B = 0x00, CIN = 1 -> SUM = 0x80, COUT = 0, OVF = 1.
- Subtract: A = 0x10, B = 0x20, CIN = 0, SUB = 1 -> SUM = 0xF0, COUT = 0, OVF = 0. Also A = 0x20, B = 0x10, CIN = 1, SUB = 1 -> SUM = 0x0F, COUT = 1.
- Handshake: pulse START with A = 0x01, B = 0x01, then pulse START again in RUN cycle 3 with A = 0xAA -> first result SUM = 0x02 only, no second DONE. START in the DONE cycle -> new operation begins on the next edge, and SUM holds 0x02 until its DONE.
- Abort plus sweep: RST_N low in RUN cycle 4 -> outputs all 0 immediately, no DONE. Then WIDTH = 2 exhaustive over A, B, CIN and SUB (64 cases) against a reference model: SUM, COUT and OVF all match.
